// File: rtl/arb_mux_n.sv
// -----------------------------------------------------------------------------
// arb_mux_n
//   N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on
//   every channel. The selected channel is picked by an internal arbiter,
//   either round-robin (RR=1) or fixed priority with the lowest index winning
//   (RR=0). One output register stage; sustains one transfer per cycle.
//
// Ports
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   in_data   in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid  in   N        channel i offers a word
//   in_ready  out  N        channel i word is taken this cycle (one-hot or zero)
//   out_data  out  WIDTH    registered selected word
//   out_valid out  1        out_data holds an untaken word
//   out_ready in   1        consumer takes out_data this cycle
//   out_sel   out  SW       index of the channel that supplied out_data
//
// in_ready is a combinational function of out_ready and in_valid; producers
// must not derive in_valid from in_ready.
// -----------------------------------------------------------------------------
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 1,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   out_data_r;
  logic [SW-1:0]      out_sel_r;
  logic [SW-1:0]      ptr_r;

  logic               accept_s;
  logic               any_valid_s;
  logic               xfer_s;
  logic [N-1:0]       grant_s;
  logic [SW-1:0]      gnt_idx_s;
  logic [WIDTH-1:0]   gnt_data_s;
  logic [SW-1:0]      ptr_next_s;
  logic               found_s;
  int                 search_s;
  logic [SW-1:0]      search_idx_s;

  // Output stage can take a new word when empty or when its word leaves now.
  always_comb begin
    accept_s    = (~out_valid_r) | out_ready;
    any_valid_s = |in_valid;
    xfer_s      = accept_s & any_valid_s;
  end

  // Arbiter: scan channels starting at ptr (round-robin) or at 0 (fixed
  // priority); wrap is modulo N so non-power-of-two N works.
  always_comb begin
    grant_s      = {N{1'b0}};
    gnt_idx_s    = {SW{1'b0}};
    found_s      = 1'b0;
    search_s     = 0;
    search_idx_s = {SW{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (RR != 0) begin
        search_s = int'(ptr_r) + k;
      end else begin
        search_s = k;
      end
      if (search_s >= N) begin
        search_s = search_s - N;
      end else begin
        search_s = search_s;
      end
      search_idx_s = SW'(search_s);
      if (!found_s && in_valid[search_idx_s]) begin
        grant_s[search_idx_s] = 1'b1;
        gnt_idx_s             = search_idx_s;
        found_s               = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Data mux driven by the one-hot grant.
  always_comb begin
    gnt_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (grant_s[i]) begin
        gnt_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // Round-robin pointer moves to the channel after the winner, wrapping at N-1.
  always_comb begin
    if (gnt_idx_s == SW'(N - 1)) begin
      ptr_next_s = {SW{1'b0}};
    end else begin
      ptr_next_s = gnt_idx_s + SW'(1);
    end
  end

  // Handshake back to producers: only the granted channel, only when accepting.
  always_comb begin
    if (accept_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = {N{1'b0}};
    end
  end

  // Output-stage FSM with its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= {SW{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (xfer_s) begin
            state_r     <= FULL;
            out_valid_r <= 1'b1;
            out_data_r  <= gnt_data_s;
            out_sel_r   <= gnt_idx_s;
          end else begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (xfer_s) begin
              // Drain and reload in the same cycle.
              state_r     <= FULL;
              out_valid_r <= 1'b1;
              out_data_r  <= gnt_data_s;
              out_sel_r   <= gnt_idx_s;
            end else begin
              state_r     <= EMPTY;
              out_valid_r <= 1'b0;
            end
          end else begin
            // Back-pressure: hold word, select and valid.
            state_r     <= FULL;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          out_data_r  <= {WIDTH{1'b0}};
          out_sel_r   <= {SW{1'b0}};
        end
      endcase
    end
  end

  generate
    if (RR != 0) begin : g_rr_ptr
      // Pointer advances only on a transfer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_r <= {SW{1'b0}};
        end else if (xfer_s) begin
          ptr_r <= ptr_next_s;
        end else begin
          ptr_r <= ptr_r;
        end
      end
    end else begin : g_fixed_ptr
      // Fixed priority never moves the pointer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_r <= {SW{1'b0}};
        end else begin
          ptr_r <= {SW{1'b0}};
        end
      end
    end
  endgenerate

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_arb_mux_n.sv
module tb_arb_mux_n;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;

  logic [N*W-1:0] data_rr;
  logic [N-1:0]   valid_rr;
  logic [N-1:0]   ready_rr;
  logic [W-1:0]   odata_rr;
  logic           ovalid_rr;
  logic           ordy_rr;
  logic [1:0]     osel_rr;

  logic [N*W-1:0] data_fp;
  logic [N-1:0]   valid_fp;
  logic [N-1:0]   ready_fp;
  logic [W-1:0]   odata_fp;
  logic           ovalid_fp;
  logic           ordy_fp;
  logic [1:0]     osel_fp;

  int checks;
  int errors;

  arb_mux_n #(.WIDTH(W), .N(N), .RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data(data_rr), .in_valid(valid_rr), .in_ready(ready_rr),
    .out_data(odata_rr), .out_valid(ovalid_rr), .out_ready(ordy_rr),
    .out_sel(osel_rr)
  );

  arb_mux_n #(.WIDTH(W), .N(N), .RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .in_data(data_fp), .in_valid(valid_fp), .in_ready(ready_fp),
    .out_data(odata_fp), .out_valid(ovalid_fp), .out_ready(ordy_fp),
    .out_sel(osel_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic set_rr(input int ch, input logic [W-1:0] v);
    data_rr[ch*W +: W] = v;
  endtask

  task automatic set_fp(input int ch, input logic [W-1:0] v);
    data_fp[ch*W +: W] = v;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ovalid_rr !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ovalid_rr); end
    checks++; if (odata_rr !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", odata_rr); end
    checks++; if (osel_rr !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d expected 0", osel_rr); end
    checks++; if (ovalid_fp !== 1'b0) begin errors++; $display("FAIL rst_valid_fp: got %b expected 0", ovalid_fp); end
    rst_n = 1'b1;
    @(negedge clk);
    set_rr(2, 32'h1234_5678);
    valid_rr = 4'b0100;
    ordy_rr  = 1'b0;
    #1;
    checks++; if (ready_rr !== 4'b0100) begin errors++; $display("FAIL rst_load_ready: got %b expected 0100", ready_rr); end
    @(posedge clk); #1;
    checks++; if (ovalid_rr !== 1'b1 || odata_rr !== 32'h1234_5678 || osel_rr !== 2'd2) begin
      errors++; $display("FAIL rst_full: got v=%b d=%h s=%0d expected v=1 d=12345678 s=2", ovalid_rr, odata_rr, osel_rr);
    end
    @(negedge clk);
    valid_rr = 4'b0000;
    rst_n = 1'b0;
    #1;
    checks++; if (ovalid_rr !== 1'b0 || odata_rr !== 32'h0 || osel_rr !== 2'd0) begin
      errors++; $display("FAIL rst_async: got v=%b d=%h s=%0d expected v=0 d=0 s=0", ovalid_rr, odata_rr, osel_rr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fairness;
    int cnt [N];
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      set_rr(i, 32'hB0 + i);
    end
    ordy_rr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      valid_rr = 4'b1111;
      #1;
      checks++; if (ready_rr !== 4'(1 << (c % 4))) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, ready_rr, 4'(1 << (c % 4)));
      end
      for (int i = 0; i < N; i++) begin
        if (ready_rr[i]) cnt[i]++;
      end
      @(posedge clk); #1;
      checks++; if (osel_rr !== 2'(c % 4) || odata_rr !== 32'hB0 + (c % 4) || ovalid_rr !== 1'b1) begin
        errors++; $display("FAIL rr_out[%0d]: got s=%0d d=%h v=%b expected s=%0d d=%h v=1", c, osel_rr, odata_rr, ovalid_rr, c % 4, 32'hB0 + (c % 4));
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (cnt[i] != 2) begin errors++; $display("FAIL rr_count[%0d]: got %0d expected 2", i, cnt[i]); end
    end
    @(negedge clk);
    valid_rr = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    ordy_rr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_rr(2, 32'hA0 + i);
      valid_rr = 4'b0100;
      #1;
      checks++; if (ready_rr !== 4'b0100) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 0100", i, ready_rr); end
      @(posedge clk); #1;
      checks++; if (odata_rr !== 32'hA0 + i || osel_rr !== 2'd2 || ovalid_rr !== 1'b1) begin
        errors++; $display("FAIL stream_out[%0d]: got d=%h s=%0d v=%b expected d=%h s=2 v=1", i, odata_rr, osel_rr, ovalid_rr, 32'hA0 + i);
      end
    end
    @(negedge clk);
    valid_rr = 4'b0000;
    #1;
    checks++; if (ready_rr !== 4'b0000) begin errors++; $display("FAIL stream_idle_ready: got %b expected 0000", ready_rr); end
    @(posedge clk); #1;
    checks++; if (ovalid_rr !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", ovalid_rr); end
  endtask

  task automatic test_wrap;
    // ptr is 3 here (last grant was channel 2).
    ordy_rr = 1'b1;
    @(negedge clk);
    set_rr(0, 32'hC0); set_rr(1, 32'hC1); set_rr(3, 32'hC3);
    valid_rr = 4'b0001;
    #1;
    checks++; if (ready_rr !== 4'b0001) begin errors++; $display("FAIL wrap_ready0: got %b expected 0001", ready_rr); end
    @(posedge clk); #1;
    checks++; if (osel_rr !== 2'd0 || odata_rr !== 32'hC0) begin errors++; $display("FAIL wrap_out0: got s=%0d d=%h expected s=0 d=c0", osel_rr, odata_rr); end
    @(negedge clk);
    valid_rr = 4'b1010;
    #1;
    checks++; if (ready_rr !== 4'b0010) begin errors++; $display("FAIL wrap_ready1: got %b expected 0010", ready_rr); end
    @(posedge clk); #1;
    checks++; if (osel_rr !== 2'd1 || odata_rr !== 32'hC1) begin errors++; $display("FAIL wrap_out1: got s=%0d d=%h expected s=1 d=c1", osel_rr, odata_rr); end
    // ptr is 2: channel 3 beats channel 0.
    @(negedge clk);
    valid_rr = 4'b1001;
    #1;
    checks++; if (ready_rr !== 4'b1000) begin errors++; $display("FAIL wrap_ready3: got %b expected 1000", ready_rr); end
    @(posedge clk); #1;
    checks++; if (osel_rr !== 2'd3 || odata_rr !== 32'hC3) begin errors++; $display("FAIL wrap_out3: got s=%0d d=%h expected s=3 d=c3", osel_rr, odata_rr); end
  endtask

  task automatic test_backpressure;
    // ptr is 0 here.
    ordy_rr = 1'b1;
    @(negedge clk);
    set_rr(0, 32'h55);
    valid_rr = 4'b0001;
    #1;
    checks++; if (ready_rr !== 4'b0001) begin errors++; $display("FAIL bp_load_ready: got %b expected 0001", ready_rr); end
    @(posedge clk); #1;
    checks++; if (odata_rr !== 32'h55 || ovalid_rr !== 1'b1) begin errors++; $display("FAIL bp_load: got d=%h v=%b expected d=55 v=1", odata_rr, ovalid_rr); end
    // ptr is 1 now.
    for (int i = 0; i < N; i++) set_rr(i, 32'h60 + i);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid_rr = 4'b1111;
      ordy_rr  = 1'b0;
      #1;
      checks++; if (ready_rr !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, ready_rr); end
      @(posedge clk); #1;
      checks++; if (odata_rr !== 32'h55 || osel_rr !== 2'd0 || ovalid_rr !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got d=%h s=%0d v=%b expected d=55 s=0 v=1", c, odata_rr, osel_rr, ovalid_rr);
      end
    end
    @(negedge clk);
    ordy_rr = 1'b1;
    #1;
    checks++; if (ready_rr !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", ready_rr); end
    @(posedge clk); #1;
    checks++; if (odata_rr !== 32'h61 || osel_rr !== 2'd1) begin errors++; $display("FAIL bp_release: got d=%h s=%0d expected d=61 s=1", odata_rr, osel_rr); end
    @(negedge clk);
    valid_rr = 4'b0000;
  endtask

  task automatic test_fixed_prio;
    ordy_fp = 1'b1;
    set_fp(1, 32'hD1);
    set_fp(3, 32'hD3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      valid_fp = 4'b1010;
      #1;
      checks++; if (ready_fp !== 4'b0010) begin errors++; $display("FAIL fp_ready[%0d]: got %b expected 0010", c, ready_fp); end
      @(posedge clk); #1;
      checks++; if (osel_fp !== 2'd1 || odata_fp !== 32'hD1) begin errors++; $display("FAIL fp_out[%0d]: got s=%0d d=%h expected s=1 d=d1", c, osel_fp, odata_fp); end
    end
    @(negedge clk);
    valid_fp = 4'b1000;
    #1;
    checks++; if (ready_fp !== 4'b1000) begin errors++; $display("FAIL fp_ready3: got %b expected 1000", ready_fp); end
    @(posedge clk); #1;
    checks++; if (osel_fp !== 2'd3 || odata_fp !== 32'hD3) begin errors++; $display("FAIL fp_out3: got s=%0d d=%h expected s=3 d=d3", osel_fp, odata_fp); end
    @(negedge clk);
    valid_fp = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    data_rr  = '0;
    valid_rr = 4'b0000;
    ordy_rr  = 1'b1;
    data_fp  = '0;
    valid_fp = 4'b0000;
    ordy_fp  = 1'b1;

    test_reset();
    test_fairness();
    test_stream();
    test_wrap();
    test_backpressure();
    test_fixed_prio();

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
